// File: rtl/dplbuf_mm_req_bridge_if.sv
// Request/response and decoder MM bus bundle for dplbuf_mm_req_bridge.
// The bridge uses the slave modport; the PCIe app / decoder side uses master.
interface dplbuf_mm_req_bridge_if #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned TAG_W  = 8
) ();
   // request channel
   logic              iREQ_VALID;
   logic              oREQ_READY;
   logic              iREQ_WRITE;
   logic [ADDR_W-1:0] iREQ_ADDR;
   logic [DATA_W-1:0] iREQ_WDATA;
   logic [TAG_W-1:0]  iREQ_TAG;
   // response channel
   logic              oRSP_VALID;
   logic              iRSP_READY;
   logic [TAG_W-1:0]  oRSP_TAG;
   logic [DATA_W-1:0] oRSP_DATA;
   logic              oRSP_ERR;
   // decoder MM side
   logic [ADDR_W-1:0] oMM_ADDR;
   logic              oMM_WR_EN;
   logic              oMM_RD_EN;
   logic [DATA_W-1:0] oMM_WR_DATA;
   logic [DATA_W-1:0] iMM_RD_DATA;
   logic              iMM_RD_DATA_V;

   modport slave (
      input  iREQ_VALID, iREQ_WRITE, iREQ_ADDR, iREQ_WDATA, iREQ_TAG,
      output oREQ_READY,
      output oRSP_VALID, oRSP_TAG, oRSP_DATA, oRSP_ERR,
      input  iRSP_READY,
      output oMM_ADDR, oMM_WR_EN, oMM_RD_EN, oMM_WR_DATA,
      input  iMM_RD_DATA, iMM_RD_DATA_V
   );

   modport master (
      output iREQ_VALID, iREQ_WRITE, iREQ_ADDR, iREQ_WDATA, iREQ_TAG,
      input  oREQ_READY,
      input  oRSP_VALID, oRSP_TAG, oRSP_DATA, oRSP_ERR,
      output iRSP_READY,
      input  oMM_ADDR, oMM_WR_EN, oMM_RD_EN, oMM_WR_DATA,
      output iMM_RD_DATA, iMM_RD_DATA_V
   );
endinterface

// File: rtl/dplbuf_mm_req_bridge.sv
// Upstream request bridge of the DPL buffer address decoder: single-beat requests to
// one-cycle MM strobes, one read outstanding, read data or timeout error word returned.
// Optional statistics counters are built when DPLBUF_MM_STATS_EN is defined.
module dplbuf_mm_req_bridge #(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   dplbuf_mm_req_bridge_if.slave bus,
   output logic [15:0] oSTAT_RD_CNT,
   output logic [15:0] oSTAT_WR_CNT,
   output logic [15:0] oSTAT_TO_CNT,
   output logic [15:0] oSTAT_STALE_CNT
);

   localparam int unsigned TMR_W = 10;
   localparam int unsigned CNT_W = 16;
   localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RSP  = 2'd2;

   logic [1:0]        state_q,       state_d;
   logic [TMR_W-1:0]  timer_q,       timer_d;
   logic              req_ready_q,   req_ready_d;
   logic [ADDR_W-1:0] mm_addr_q,     mm_addr_d;
   logic [DATA_W-1:0] mm_wr_data_q,  mm_wr_data_d;
   logic              mm_wr_en_q,    mm_wr_en_d;
   logic              mm_rd_en_q,    mm_rd_en_d;
   logic              rsp_valid_q,   rsp_valid_d;
   logic [TAG_W-1:0]  rsp_tag_q,     rsp_tag_d;
   logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;
   logic              rsp_err_q,     rsp_err_d;
   logic [DATA_W-1:0] err_word;

   // Timeout word: marker in the top 32 bits, outstanding word address at the bottom.
   always_comb begin
      err_word                   = '0;
      err_word[DATA_W-1 -: 32]   = 32'hDEAD_BEEF;
      err_word[ADDR_W-1:0]       = mm_addr_q;
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      mm_addr_d    = mm_addr_q;
      mm_wr_data_d = mm_wr_data_q;
      mm_wr_en_d   = 1'b0;
      mm_rd_en_d   = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.iREQ_VALID) begin
               mm_addr_d = bus.iREQ_ADDR;
               if (bus.iREQ_WRITE) begin
                  mm_wr_en_d   = 1'b1;
                  mm_wr_data_d = bus.iREQ_WDATA;
               end else begin
                  mm_rd_en_d = 1'b1;
                  rsp_tag_d  = bus.iREQ_TAG;
                  timer_d    = '0;
                  state_d    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Decoder data takes priority over a timeout expiring in the same cycle.
            if (bus.iMM_RD_DATA_V) begin
               rsp_data_d  = bus.iMM_RD_DATA;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end else if (timer_q == TO_LAST) begin
               rsp_data_d  = err_word;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end else begin
               timer_d = TMR_W'(timer_q + 1'b1);
            end
         end
         ST_RSP: begin
            if (bus.iRSP_READY) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         req_ready_q  <= 1'b1;
         mm_addr_q    <= '0;
         mm_wr_data_q <= '0;
         mm_wr_en_q   <= 1'b0;
         mm_rd_en_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         req_ready_q  <= req_ready_d;
         mm_addr_q    <= mm_addr_d;
         mm_wr_data_q <= mm_wr_data_d;
         mm_wr_en_q   <= mm_wr_en_d;
         mm_rd_en_q   <= mm_rd_en_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.oREQ_READY  = req_ready_q;
   assign bus.oRSP_VALID  = rsp_valid_q;
   assign bus.oRSP_TAG    = rsp_tag_q;
   assign bus.oRSP_DATA   = rsp_data_q;
   assign bus.oRSP_ERR    = rsp_err_q;
   assign bus.oMM_ADDR    = mm_addr_q;
   assign bus.oMM_WR_EN   = mm_wr_en_q;
   assign bus.oMM_RD_EN   = mm_rd_en_q;
   assign bus.oMM_WR_DATA = mm_wr_data_q;

`ifdef DPLBUF_MM_STATS_EN
   localparam int unsigned N_CNT = 4;

   logic [N_CNT-1:0]            cnt_evt;
   logic [N_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Events: 0 read issued, 1 write issued, 2 timeout, 3 stale read-valid.
   always_comb begin
      cnt_evt    = '0;
      cnt_evt[0] = (state_q == ST_IDLE) && bus.iREQ_VALID && !bus.iREQ_WRITE;
      cnt_evt[1] = (state_q == ST_IDLE) && bus.iREQ_VALID &&  bus.iREQ_WRITE;
      cnt_evt[2] = (state_q == ST_WAIT) && !bus.iMM_RD_DATA_V && (timer_q == TO_LAST);
      cnt_evt[3] = (state_q != ST_WAIT) && bus.iMM_RD_DATA_V;
      cnt_d      = cnt_q;
      for (int i = 0; i < N_CNT; i++) begin
         if (cnt_evt[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign oSTAT_RD_CNT    = cnt_q[0];
   assign oSTAT_WR_CNT    = cnt_q[1];
   assign oSTAT_TO_CNT    = cnt_q[2];
   assign oSTAT_STALE_CNT = cnt_q[3];
`else
   assign oSTAT_RD_CNT    = '0;
   assign oSTAT_WR_CNT    = '0;
   assign oSTAT_TO_CNT    = '0;
   assign oSTAT_STALE_CNT = '0;
`endif

endmodule

// File: tb/tb_dplbuf_mm_req_bridge.sv
// Directed bench for dplbuf_mm_req_bridge: writes, read with data, timeout,
// backpressure, back-to-back writes, reset mid-read, data/timeout collision.
module tb_dplbuf_mm_req_bridge;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned TAG_W   = 8;
   localparam int unsigned TIMEOUT = 64;
`ifdef DPLBUF_MM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] stat_rd, stat_wr, stat_to, stat_stale;
   int          n_cmp;
   int          n_err;
   logic [63:0] held_data;

   dplbuf_mm_req_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   dplbuf_mm_req_bridge #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .oSTAT_RD_CNT   (stat_rd),
      .oSTAT_WR_CNT   (stat_wr),
      .oSTAT_TO_CNT   (stat_to),
      .oSTAT_STALE_CNT(stat_stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sx(input int n);
      return STATS ? 16'(n) : 16'h0;
   endfunction

   task automatic chk_stats(input string tag, input int rd, input int wr, input int to, input int st);
      chk({tag, "_rd_cnt"},    64'(stat_rd),    64'(sx(rd)));
      chk({tag, "_wr_cnt"},    64'(stat_wr),    64'(sx(wr)));
      chk({tag, "_to_cnt"},    64'(stat_to),    64'(sx(to)));
      chk({tag, "_stale_cnt"}, 64'(stat_stale), 64'(sx(st)));
   endtask

   task automatic issue_read(input logic [13:0] a, input logic [7:0] t);
      bus.iREQ_VALID = 1'b1;
      bus.iREQ_WRITE = 1'b0;
      bus.iREQ_ADDR  = a;
      bus.iREQ_TAG   = t;
      step();
      bus.iREQ_VALID = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.iREQ_VALID    = 1'b0;
      bus.iREQ_WRITE    = 1'b0;
      bus.iREQ_ADDR     = '0;
      bus.iREQ_WDATA    = '0;
      bus.iREQ_TAG      = '0;
      bus.iRSP_READY    = 1'b0;
      bus.iMM_RD_DATA   = '0;
      bus.iMM_RD_DATA_V = 1'b0;
      step();
      step();

      // reset state
      chk("rst_req_ready", 64'(bus.oREQ_READY), 64'd1);
      chk("rst_rsp_valid", 64'(bus.oRSP_VALID), 64'd0);
      chk("rst_wr_en",     64'(bus.oMM_WR_EN),  64'd0);
      chk("rst_rd_en",     64'(bus.oMM_RD_EN),  64'd0);
      chk("rst_addr",      64'(bus.oMM_ADDR),   64'd0);
      chk("rst_rsp_data",  bus.oRSP_DATA,       64'd0);
      chk_stats("rst", 0, 0, 0, 0);
      rst_n = 1'b1;
      step();

      // single write
      bus.iREQ_VALID = 1'b1;
      bus.iREQ_WRITE = 1'b1;
      bus.iREQ_ADDR  = 14'h0405;
      bus.iREQ_WDATA = 64'h1122_3344_5566_7788;
      step();
      bus.iREQ_VALID = 1'b0;
      chk("wr_en_pulse", 64'(bus.oMM_WR_EN),  64'd1);
      chk("wr_addr",     64'(bus.oMM_ADDR),   64'h0405);
      chk("wr_data",     bus.oMM_WR_DATA,     64'h1122_3344_5566_7788);
      chk("wr_no_rsp",   64'(bus.oRSP_VALID), 64'd0);
      chk("wr_no_rd",    64'(bus.oMM_RD_EN),  64'd0);
      chk("wr_ready",    64'(bus.oREQ_READY), 64'd1);
      step();
      chk("wr_en_drop",  64'(bus.oMM_WR_EN),  64'd0);
      chk("wr_addr_hold",64'(bus.oMM_ADDR),   64'h0405);

      // read answered 3 cycles after the strobe
      issue_read(14'h0800, 8'h3C);
      chk("rd_en_pulse", 64'(bus.oMM_RD_EN),  64'd1);
      chk("rd_addr",     64'(bus.oMM_ADDR),   64'h0800);
      chk("rd_not_ready",64'(bus.oREQ_READY), 64'd0);
      step();
      chk("rd_en_drop",  64'(bus.oMM_RD_EN),  64'd0);
      step();
      step();
      bus.iMM_RD_DATA   = 64'hCAFE_0000_CAFE_0001;
      bus.iMM_RD_DATA_V = 1'b1;
      step();
      bus.iMM_RD_DATA_V = 1'b0;
      bus.iMM_RD_DATA   = 64'h0;
      chk("rd_rsp_valid", 64'(bus.oRSP_VALID), 64'd1);
      chk("rd_rsp_data",  bus.oRSP_DATA,       64'hCAFE_0000_CAFE_0001);
      chk("rd_rsp_tag",   64'(bus.oRSP_TAG),   64'h3C);
      chk("rd_rsp_err",   64'(bus.oRSP_ERR),   64'd0);

      // backpressure: response held for 10 cycles
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", 64'(bus.oRSP_VALID), 64'd1);
         chk("bp_data",  bus.oRSP_DATA,       64'hCAFE_0000_CAFE_0001);
         chk("bp_tag",   64'(bus.oRSP_TAG),   64'h3C);
         chk("bp_err",   64'(bus.oRSP_ERR),   64'd0);
         chk("bp_ready", 64'(bus.oREQ_READY), 64'd0);
      end
      bus.iRSP_READY = 1'b1;
      step();
      bus.iRSP_READY = 1'b0;
      chk("acc_valid_drop", 64'(bus.oRSP_VALID), 64'd0);
      chk("acc_ready",      64'(bus.oREQ_READY), 64'd1);

      // four back-to-back writes
      bus.iREQ_VALID = 1'b1;
      bus.iREQ_WRITE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.iREQ_ADDR  = 14'(16'h0010 + i);
         bus.iREQ_WDATA = 64'(64'hA000 + i);
         step();
         chk("b2b_wr_en",   64'(bus.oMM_WR_EN),   64'd1);
         chk("b2b_wr_addr", 64'(bus.oMM_ADDR),    64'(16'h0010 + i));
         chk("b2b_wr_data", bus.oMM_WR_DATA,      64'(64'hA000 + i));
      end
      bus.iREQ_VALID = 1'b0;
      step();
      chk("b2b_wr_end", 64'(bus.oMM_WR_EN), 64'd0);
      chk_stats("mid", 1, 5, 0, 0);

      // timeout: decoder silent
      issue_read(14'h3FFF, 8'h55);
      chk("to_rd_en", 64'(bus.oMM_RD_EN), 64'd1);
      for (int i = 1; i < int'(TIMEOUT); i++) step();
      chk("to_not_early", 64'(bus.oRSP_VALID), 64'd0);
      step();
      chk("to_rsp_valid", 64'(bus.oRSP_VALID), 64'd1);
      chk("to_rsp_err",   64'(bus.oRSP_ERR),   64'd1);
      chk("to_rsp_data",  bus.oRSP_DATA,       64'hDEAD_BEEF_0000_3FFF);
      chk("to_rsp_tag",   64'(bus.oRSP_TAG),   64'h55);
      for (int i = 0; i < 4; i++) step();
      bus.iMM_RD_DATA   = 64'h1234_5678_9ABC_DEF0;
      bus.iMM_RD_DATA_V = 1'b1;
      step();
      bus.iMM_RD_DATA_V = 1'b0;
      held_data = bus.oRSP_DATA;
      chk("late_data_ignored", held_data,          64'hDEAD_BEEF_0000_3FFF);
      chk("late_err_kept",     64'(bus.oRSP_ERR),  64'd1);
      chk("late_valid_kept",   64'(bus.oRSP_VALID),64'd1);
      chk_stats("to", 2, 5, 1, 1);
      bus.iRSP_READY = 1'b1;
      step();
      bus.iRSP_READY = 1'b0;
      chk("to_acc_ready", 64'(bus.oREQ_READY), 64'd1);

      // data arriving in the timer's last cycle wins
      issue_read(14'h0123, 8'h77);
      for (int i = 1; i < int'(TIMEOUT); i++) step();
      chk("col_not_early", 64'(bus.oRSP_VALID), 64'd0);
      bus.iMM_RD_DATA   = 64'hA5A5_5A5A_0F0F_F0F0;
      bus.iMM_RD_DATA_V = 1'b1;
      step();
      bus.iMM_RD_DATA_V = 1'b0;
      chk("col_rsp_valid", 64'(bus.oRSP_VALID), 64'd1);
      chk("col_rsp_err",   64'(bus.oRSP_ERR),   64'd0);
      chk("col_rsp_data",  bus.oRSP_DATA,       64'hA5A5_5A5A_0F0F_F0F0);
      chk("col_rsp_tag",   64'(bus.oRSP_TAG),   64'h77);
      chk_stats("col", 3, 5, 1, 1);
      bus.iRSP_READY = 1'b1;
      step();
      bus.iRSP_READY = 1'b0;

      // reset while a read is outstanding
      issue_read(14'h0200, 8'h11);
      step();
      chk("mr_waiting", 64'(bus.oREQ_READY), 64'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mr_ready",     64'(bus.oREQ_READY), 64'd1);
      chk("mr_rsp_valid", 64'(bus.oRSP_VALID), 64'd0);
      chk("mr_rd_en",     64'(bus.oMM_RD_EN),  64'd0);
      chk("mr_wr_en",     64'(bus.oMM_WR_EN),  64'd0);
      chk_stats("mr", 0, 0, 0, 0);
      for (int i = 0; i < int'(TIMEOUT) + 4; i++) step();
      chk("mr_no_rsp",    64'(bus.oRSP_VALID), 64'd0);
      chk("mr_no_strobe", 64'(bus.oMM_RD_EN),  64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
